// File: rtl/divider_check_mul_seq.sv
// Shift-add multiply-accumulate that rebuilds a divider's dividend as P = Q*B + R.
// One divisor bit is consumed per clock, so a result is ready a fixed BW edges after accept.
module divider_check_mul_seq #(
  parameter int QW = 32,
  parameter int BW = 16,
  parameter int PW = QW + BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q_in,
  input  logic [BW-1:0] b_in,
  input  logic [QW-1:0] r_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic [QW-1:0] a_rebuilt,
  output logic          overflow,
  output logic          rem_err
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | BW shift-add iterations in progress
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_mcand;
  logic [BW-1:0] r_mplier;
  logic [CW-1:0] r_cnt;
  logic          r_rem_err_lat;
  logic [PW-1:0] r_product;
  logic          r_overflow;
  logic          r_rem_err;

  logic [PW-1:0] w_acc_next;
  logic          w_rem_err_in;

  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  // B is widened to QW bits so the remainder compare is unsigned and exact.
  assign w_rem_err_in = (b_in == '0) || (r_in >= QW'(b_in));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_cnt         <= '0;
      r_rem_err_lat <= 1'b0;
      r_product     <= '0;
      r_overflow    <= 1'b0;
      r_rem_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc         <= {{BW{1'b0}}, r_in};
            r_mcand       <= {{BW{1'b0}}, q_in};
            r_mplier      <= b_in;
            r_rem_err_lat <= w_rem_err_in;
            r_cnt         <= '0;
            r_in_ready    <= 1'b0;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(BW - 1)) begin
            r_product   <= w_acc_next;
            r_overflow  <= |w_acc_next[PW-1:QW];
            r_rem_err   <= r_rem_err_lat;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign a_rebuilt = r_product[QW-1:0];
  assign overflow  = r_overflow;
  assign rem_err   = r_rem_err;

endmodule
